// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one unsigned add/subtract unit among NUM_REQ requesters.
// One operation is in flight at a time; the result is held in a single-entry response buffer.
module addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_op,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [DW-1:0]         resp_result,
    output logic                  resp_overflow,
    output logic                  resp_underflow,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic           op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [DW-1:0]  resp_result_q, resp_result_d;
    logic           resp_ovf_q, resp_ovf_d;
    logic           resp_unf_q, resp_unf_d;

    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic [DW:0]    sum;
    logic [DW:0]    diff;

    // Search starts one past the last winner, so the previous grantee has lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that leaves one
        // unassigned would infer a latch.
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDW'((int'(rr_ptr_q) + off) % NUM_REQ);
            if (!grant_valid && req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // The MSB of the widened subtraction is the borrow, i.e. a < b.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        id_d          = id_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_ovf_d    = resp_ovf_q;
        resp_unf_d    = resp_unf_q;
        req_ready     = '0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req_ready[grant_id] = 1'b1;
                    a_d      = req_a[int'(grant_id)*DW +: DW];
                    b_d      = req_b[int'(grant_id)*DW +: DW];
                    op_d     = req_op[grant_id];
                    id_d     = grant_id;
                    rr_ptr_d = grant_id;
                    state_d  = CALC;
                end
            end
            CALC: begin
                resp_result_d = op_q ? diff[DW-1:0] : sum[DW-1:0];
                resp_ovf_d    = !op_q && sum[DW];
                resp_unf_d    = op_q && diff[DW];
                resp_id_d     = id_q;
                resp_valid_d  = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so every register samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= IDW'(NUM_REQ - 1);
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= 1'b0;
            id_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_ovf_q    <= 1'b0;
            resp_unf_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            id_q          <= id_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_ovf_q    <= resp_ovf_d;
            resp_unf_q    <= resp_unf_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_result    = resp_result_q;
    assign resp_overflow  = resp_ovf_q;
    assign resp_underflow = resp_unf_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 8-bit unsigned add/subtract unit among NUM_REQ requesters.
- Each requester has a valid/ready request port. A round-robin arbiter grants one request at a time.
- Operands are captured and the result is computed into a register. A single-entry response buffer holds the result until the consumer accepts it.
- Sits between the command issuers and the combinational adder datapath, sequencing access so that only one operation is in flight.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥ 2.
- DW, 8, operand/result width.
- IDW, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_op  in  NUM_REQ  per-requester opcode: 0 = add, 1 = subtract (a−b).
- req_a  in  NUM_REQ*DW  packed operand A; requester i occupies bits [i*DW +: DW].
- req_b  in  NUM_REQ*DW  packed operand B, same packing as req_a.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_result  out  DW  result modulo 2^DW.
- resp_overflow  out  1  add carry-out.
- resp_underflow  out  1  subtract borrow (a < b).
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- FSM states: IDLE, CALC, RESP.
- Reset values: state = IDLE; rr_ptr = NUM_REQ−1 (so requester 0 has highest priority first); resp_valid = 0; resp_id = 0; resp_result = 0; resp_overflow = 0; resp_underflow = 0; captured operands = 0; busy = 0.
- Reset mid-operation discards any captured or pending response; no resp_valid pulse occurs afterwards.
- IDLE:
  - Grant = first requester with req_valid = 1, searching from (rr_ptr+1) mod NUM_REQ upward with wrap-around.
  - req_ready[grant] = 1, combinationally from req_valid and rr_ptr. All other req_ready bits are 0.
  - If no request is valid, req_ready = 0 and the FSM stays in IDLE.
  - On the accept edge: capture a, b, op and the ID; set rr_ptr = grant; go to CALC.
- CALC: req_ready = 0.
  - Add: the 9-bit sum {0,a} + {0,b} gives result = sum[7:0] and overflow = sum[8]; underflow = 0.
  - Subtract: result = (a−b) mod 256; underflow = (a < b); overflow = 0.
  - On the next edge, register the result and flags into the resp_* outputs, set resp_valid = 1, and go to RESP.
- RESP: resp_valid = 1. All resp_* outputs stay stable until resp_valid && resp_ready.
  - On that edge: resp_valid = 0 and the FSM goes to IDLE.
  - New requests are not accepted in RESP.
- Latency:
  - Accept at edge t gives resp_valid high after edge t+1.
  - With resp_ready held at 1, back-to-back throughput is one operation per 3 cycles.
- Request side rules:
  - Requesters hold req_valid and operands stable until accepted.
  - Dropping req_valid before acceptance is permitted; the arbiter simply regrants on the next IDLE cycle.
  - An ungranted requester is never starved: it is served within NUM_REQ grants.
- resp_ready while resp_valid = 0 is ignored.
- Equal operands on subtract give result 0, underflow 0.
- req_valid asserted during CALC/RESP is held off (ready low), not lost.

Test Plan:
- Reset, then req_valid[0] = 1 with add, a = 200, b = 100 → req_ready[0] pulses for 1 cycle; 2 cycles after accept, resp_valid = 1, resp_id = 0, result = 44, overflow = 1, underflow = 0.
- Requester 2 subtract, a = 5, b = 9 → result = 252, underflow = 1, overflow = 0; requester 2 subtract, a = 9, b = 9 → result = 0, both flags 0.
- All 4 requesters hold valid continuously with resp_ready = 1 → grant order is 0, 1, 2, 3, 0, 1 …; responses are spaced 3 cycles apart; each resp_id matches its operands.
- resp_ready held 0 for 5 cycles while in RESP → resp_* stay stable, req_ready stays 0, busy = 1; raising resp_ready completes the handshake and the FSM returns to IDLE.
- Assert reset while in CALC with a pending add of 255+1 → all outputs reach their reset values the next cycle; no response appears; rr_ptr restarts so requester 0 wins first.
- Only requester 3 valid with rr_ptr = 3 → wrap-around search grants requester 3; then requesters 1 and 3 both valid → requester 1 is granted next.
